ex_alu_muldiv: RTL and testbench

- Parametrised EX-stage ALU for the MIPS32 pipeline.
- Keeps the legacy single-cycle ALU operations and adds XOR, NOR, SLTU, shifts, a signed-overflow flag and an iterative multiply/divide unit with HI/LO registers.
- Multi-cycle operations use a start/busy/done handshake. Stall_EX freezes the upstream pipeline while the result is not yet available.

---
 rtl/alu_pkg.sv | 42 ++++
 rtl/ex_alu_muldiv_if.sv | 31 +++
 rtl/ex_muldiv_iter.sv | 137 +++++++++++++
 rtl/ex_alu_muldiv.sv | 80 ++++++++
 tb/tb_ex_alu_muldiv.sv | 394 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the EX-stage ALU and its iterative multiply/divide unit.
package alu_pkg;

  // Operation select codes; the original ALU codes keep their legacy values.
  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1001;
  localparam logic [3:0] OP_MFHI = 4'b1010;
  localparam logic [3:0] OP_MFLO = 4'b1011;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_MULT = 4'b1101;
  localparam logic [3:0] OP_DIV  = 4'b1110;
  localparam logic [3:0] OP_RSVD = 4'b1111;

  // Multiply/divide sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } md_state_t;

  // Remainder written on the signed most-negative / -1 overflow case.
  localparam logic [63:0] OVF_REM = 64'd0;

  // Quotient written on divide by zero: all ones of the given width.
  function automatic logic [63:0] div0_quotient(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  // Quotient written on signed overflow: the most-negative value of the given width.
  function automatic logic [63:0] most_negative(input int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/ex_alu_muldiv_if.sv
// EX-stage ALU bus: operands and controls from the pipeline, results and handshake back.
interface ex_alu_muldiv_if #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
);
  logic [WIDTH-1:0] Read_Data_1_EX;
  logic [WIDTH-1:0] ALU_Data_2_EX;
  logic [SHW-1:0]   Shamt_EX;
  logic [3:0]       ALU_Control_EX;
  logic             Unsigned_EX;
  logic             Valid_EX;
  logic             Flush_EX;
  logic [WIDTH-1:0] ALU_Result_EX;
  logic             Zero_EX;
  logic             Overflow_EX;
  logic             Busy_EX;
  logic             Done_EX;
  logic             Stall_EX;

  modport master (
    output Read_Data_1_EX, ALU_Data_2_EX, Shamt_EX, ALU_Control_EX,
           Unsigned_EX, Valid_EX, Flush_EX,
    input  ALU_Result_EX, Zero_EX, Overflow_EX, Busy_EX, Done_EX, Stall_EX
  );

  modport slave (
    input  Read_Data_1_EX, ALU_Data_2_EX, Shamt_EX, ALU_Control_EX,
           Unsigned_EX, Valid_EX, Flush_EX,
    output ALU_Result_EX, Zero_EX, Overflow_EX, Busy_EX, Done_EX, Stall_EX
  );
endinterface

// File: rtl/ex_muldiv_iter.sv
// Iterative radix-2 multiply/divide with HI/LO result registers.
module ex_muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             start_div,
  input  logic             start_unsigned,
  input  logic             flush,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam logic [63:0]      MIN_FULL  = most_negative(WIDTH);
  localparam logic [63:0]      ONES_FULL = div0_quotient(WIDTH);
  localparam logic [WIDTH-1:0] MIN_VAL   = MIN_FULL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] DIV0_Q    = ONES_FULL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] OVF_R     = OVF_REM[WIDTH-1:0];

  md_state_t          state_reg;
  logic [SHW-1:0]     count_reg;
  logic [2*WIDTH-1:0] p_reg;
  logic [WIDTH-1:0]   a_mag_reg, b_mag_reg, hi_reg, lo_reg;
  logic               sign_a_reg, sign_b_reg, is_div_reg, is_unsigned_reg, done_reg;

  // Operands are reduced to magnitudes up front; signs are re-applied in FIX.
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag_in, b_mag_in;
  assign a_neg    = !start_unsigned && op_a[WIDTH-1];
  assign b_neg    = !start_unsigned && op_b[WIDTH-1];
  assign a_mag_in = a_neg ? -op_a : op_a;
  assign b_mag_in = b_neg ? -op_b : op_b;

  // Shift-add multiply step: conditionally add multiplicand to the high half, shift right.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  assign mul_sum  = {1'b0, p_reg[2*WIDTH-1:WIDTH]} + (p_reg[0] ? {1'b0, a_mag_reg} : '0);
  assign mul_next = {mul_sum, p_reg[WIDTH-1:1]};

  // Restoring divide step: shift the partial remainder in, trial-subtract the divisor.
  logic [WIDTH:0]     div_r, div_diff;
  logic [2*WIDTH-1:0] div_next;
  assign div_r    = p_reg[2*WIDTH-1:WIDTH-1];
  assign div_diff = div_r - {1'b0, b_mag_reg};
  assign div_next = div_diff[WIDTH]
                  ? {div_r[WIDTH-1:0], p_reg[WIDTH-2:0], 1'b0}
                  : {div_diff[WIDTH-1:0], p_reg[WIDTH-2:0], 1'b1};

  // Sign correction and the special divide cases, applied when leaving FIX.
  logic [WIDTH-1:0] fix_hi, fix_lo, quot, rem;
  assign quot = p_reg[WIDTH-1:0];
  assign rem  = p_reg[2*WIDTH-1:WIDTH];
  always_comb begin
    fix_hi = '0;
    fix_lo = '0;
    if (!is_div_reg) begin
      {fix_hi, fix_lo} = (sign_a_reg ^ sign_b_reg) ? -p_reg : p_reg;
    end else if (b_mag_reg == '0) begin
      fix_lo = DIV0_Q;
      fix_hi = sign_a_reg ? -a_mag_reg : a_mag_reg;
    end else if (!is_unsigned_reg && sign_a_reg && a_mag_reg == MIN_VAL &&
                 sign_b_reg && b_mag_reg == WIDTH'(1)) begin
      fix_lo = MIN_VAL;
      fix_hi = OVF_R;
    end else begin
      fix_lo = (sign_a_reg ^ sign_b_reg) ? -quot : quot;
      fix_hi = sign_a_reg ? -rem : rem;
    end
  end

  // Sequencer: accept in IDLE, WIDTH steps in RUN, one write cycle in FIX; flush aborts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= ST_IDLE;
      count_reg       <= '0;
      p_reg           <= '0;
      a_mag_reg       <= '0;
      b_mag_reg       <= '0;
      sign_a_reg      <= 1'b0;
      sign_b_reg      <= 1'b0;
      is_div_reg      <= 1'b0;
      is_unsigned_reg <= 1'b0;
      hi_reg          <= '0;
      lo_reg          <= '0;
      done_reg        <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            a_mag_reg       <= a_mag_in;
            b_mag_reg       <= b_mag_in;
            sign_a_reg      <= a_neg;
            sign_b_reg      <= b_neg;
            is_div_reg      <= start_div;
            is_unsigned_reg <= start_unsigned;
            p_reg           <= {{WIDTH{1'b0}}, (start_div ? a_mag_in : b_mag_in)};
            count_reg       <= '0;
            state_reg       <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (flush) begin
            state_reg <= ST_IDLE;
          end else begin
            p_reg     <= is_div_reg ? div_next : mul_next;
            count_reg <= count_reg + 1'b1;
            if (count_reg == SHW'(WIDTH - 1)) state_reg <= ST_FIX;
          end
        end
        ST_FIX: begin
          state_reg <= ST_IDLE;
          if (!flush) begin
            hi_reg   <= fix_hi;
            lo_reg   <= fix_lo;
            done_reg <= 1'b1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign hi   = hi_reg;
  assign lo   = lo_reg;
  assign busy = (state_reg != ST_IDLE);
  assign done = done_reg;

endmodule

// File: rtl/ex_alu_muldiv.sv
// EX-stage ALU: combinational ops, HI/LO reads, and stall generation around the mul/div unit.
module ex_alu_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input logic           Clk,
  input logic           Reset_n,
  ex_alu_muldiv_if.slave bus
);

  logic [WIDTH-1:0] a, b, sum, diff, hi, lo, result;
  logic [SHW-1:0]   shamt;
  logic [3:0]       op;
  logic             is_md_op, reads_hilo, md_busy, md_done, overflow;

  assign a     = bus.Read_Data_1_EX;
  assign b     = bus.ALU_Data_2_EX;
  assign shamt = bus.Shamt_EX;
  assign op    = bus.ALU_Control_EX;
  assign sum   = a + b;
  assign diff  = a - b;

  assign is_md_op   = (op == OP_MULT) || (op == OP_DIV);
  assign reads_hilo = (op == OP_MFHI) || (op == OP_MFLO);

  ex_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk            (Clk),
    .rst_n          (Reset_n),
    .start          (bus.Valid_EX && is_md_op && !bus.Flush_EX),
    .start_div      (op == OP_DIV),
    .start_unsigned (bus.Unsigned_EX),
    .flush          (bus.Flush_EX),
    .op_a           (a),
    .op_b           (b),
    .hi             (hi),
    .lo             (lo),
    .busy           (md_busy),
    .done           (md_done)
  );

  // Result mux; MULT, DIV and the reserved code all return zero.
  always_comb begin
    result = '0;
    case (op)
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_ADD:  result = sum;
      OP_XOR:  result = a ^ b;
      OP_SLL:  result = b << shamt;
      OP_SRL:  result = b >> shamt;
      OP_SUB:  result = diff;
      OP_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: result = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SRA:  result = $unsigned($signed(b) >>> shamt);
      OP_MFHI: result = hi;
      OP_MFLO: result = lo;
      OP_NOR:  result = ~(a | b);
      default: result = '0;
    endcase
  end

  // Signed overflow is only meaningful for ADD and SUB.
  always_comb begin
    overflow = 1'b0;
    if (op == OP_ADD)
      overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    else if (op == OP_SUB)
      overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
  end

  assign bus.ALU_Result_EX = result;
  assign bus.Zero_EX       = (result == '0);
  assign bus.Overflow_EX   = overflow;
  assign bus.Busy_EX       = md_busy;
  assign bus.Done_EX       = md_done;
  assign bus.Stall_EX      = bus.Valid_EX && (is_md_op || reads_hilo) && md_busy;

endmodule

// File: tb/tb_ex_alu_muldiv.sv
// Directed self-checking bench for ex_alu_muldiv.
module tb_ex_alu_muldiv;
  import alu_pkg::*;

  logic Clk;
  logic Reset_n;
  int   checks = 0;
  int   fails  = 0;

  ex_alu_muldiv_if #(.WIDTH(32)) bus ();

  ex_alu_muldiv #(.WIDTH(32)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [31:0] res;
    logic        zero;
    logic        ovf;
  } vec_t;

  task automatic set_in(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh, input logic uns, input logic vld);
    bus.ALU_Control_EX = op;
    bus.Read_Data_1_EX = a;
    bus.ALU_Data_2_EX  = b;
    bus.Shamt_EX       = sh;
    bus.Unsigned_EX    = uns;
    bus.Valid_EX       = vld;
  endtask

  // Waits (bounded) for Busy_EX to fall; returns the number of edges taken.
  task automatic wait_not_busy(output int cycles);
    cycles = 0;
    while (bus.Busy_EX === 1'b1 && cycles < 200) begin
      @(posedge Clk);
      #1;
      cycles++;
    end
  endtask

  task automatic run_vectors(input string tag, input vec_t vq[$]);
    foreach (vq[i]) begin
      @(negedge Clk);
      set_in(vq[i].op, vq[i].a, vq[i].b, vq[i].sh, 1'b0, 1'b0);
      #1;
      $display("txn %s[%0d] op=%b a=%h b=%h -> res=%h z=%b v=%b", tag, i, vq[i].op,
               vq[i].a, vq[i].b, bus.ALU_Result_EX, bus.Zero_EX, bus.Overflow_EX);
      checks++;
      if (bus.ALU_Result_EX !== vq[i].res) begin
        fails++;
        $display("FAIL %s[%0d] result: got %h expected %h", tag, i, bus.ALU_Result_EX, vq[i].res);
      end
      checks++;
      if (bus.Zero_EX !== vq[i].zero) begin
        fails++;
        $display("FAIL %s[%0d] zero: got %b expected %b", tag, i, bus.Zero_EX, vq[i].zero);
      end
      checks++;
      if (bus.Overflow_EX !== vq[i].ovf) begin
        fails++;
        $display("FAIL %s[%0d] overflow: got %b expected %b", tag, i, bus.Overflow_EX, vq[i].ovf);
      end
    end
  endtask

  // Issues one MULT/DIV, checks latency, Done pulse and the HI/LO contents.
  task automatic run_md(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic uns,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int cyc;
    @(negedge Clk);
    set_in(op, a, b, 5'd0, uns, 1'b1);
    @(posedge Clk);
    #1;
    set_in(OP_AND, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
    checks++;
    if (bus.Busy_EX !== 1'b1) begin
      fails++;
      $display("FAIL %s busy_start: got %b expected 1", tag, bus.Busy_EX);
    end
    wait_not_busy(cyc);
    checks++;
    if (cyc != 33) begin
      fails++;
      $display("FAIL %s busy_cycles: got %0d expected 33", tag, cyc);
    end
    checks++;
    if (bus.Done_EX !== 1'b1) begin
      fails++;
      $display("FAIL %s done_pulse: got %b expected 1", tag, bus.Done_EX);
    end
    set_in(OP_MFHI, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1);
    #1;
    $display("txn %s a=%h b=%h cycles=%0d hi=%h", tag, a, b, cyc, bus.ALU_Result_EX);
    checks++;
    if (bus.ALU_Result_EX !== exp_hi) begin
      fails++;
      $display("FAIL %s hi: got %h expected %h", tag, bus.ALU_Result_EX, exp_hi);
    end
    set_in(OP_MFLO, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1);
    #1;
    checks++;
    if (bus.ALU_Result_EX !== exp_lo) begin
      fails++;
      $display("FAIL %s lo: got %h expected %h", tag, bus.ALU_Result_EX, exp_lo);
    end
    set_in(OP_AND, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
    @(posedge Clk);
    #1;
    checks++;
    if (bus.Done_EX !== 1'b0) begin
      fails++;
      $display("FAIL %s done_width: got %b expected 0", tag, bus.Done_EX);
    end
  endtask

  task automatic test_reset();
    bus.Flush_EX = 1'b0;
    set_in(OP_MULT, 32'd3, 32'd4, 5'd0, 1'b0, 1'b1);
    Reset_n = 1'b0;
    repeat (2) @(negedge Clk);
    checks++;
    if (bus.Busy_EX !== 1'b0 || bus.Done_EX !== 1'b0 || bus.Stall_EX !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctrl: got busy=%b done=%b stall=%b expected 0 0 0",
               bus.Busy_EX, bus.Done_EX, bus.Stall_EX);
    end
    set_in(OP_MFHI, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1);
    #1;
    checks++;
    if (bus.ALU_Result_EX !== 32'd0) begin
      fails++;
      $display("FAIL reset_hi: got %h expected 0", bus.ALU_Result_EX);
    end
    set_in(OP_MFLO, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1);
    #1;
    checks++;
    if (bus.ALU_Result_EX !== 32'd0) begin
      fails++;
      $display("FAIL reset_lo: got %h expected 0", bus.ALU_Result_EX);
    end
    $display("txn reset busy=%b done=%b", bus.Busy_EX, bus.Done_EX);
    set_in(OP_AND, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
    @(negedge Clk);
    Reset_n = 1'b1;
  endtask

  task automatic test_legacy();
    vec_t vq[$];
    vq.push_back('{OP_ADD,  32'd7, 32'd3, 5'd0, 32'd10, 1'b0, 1'b0});
    vq.push_back('{OP_SUB,  32'd7, 32'd3, 5'd0, 32'd4, 1'b0, 1'b0});
    vq.push_back('{OP_AND,  32'd7, 32'd3, 5'd0, 32'd3, 1'b0, 1'b0});
    vq.push_back('{OP_OR,   32'd7, 32'd3, 5'd0, 32'd7, 1'b0, 1'b0});
    vq.push_back('{OP_XOR,  32'd7, 32'd3, 5'd0, 32'd4, 1'b0, 1'b0});
    vq.push_back('{OP_NOR,  32'd7, 32'd3, 5'd0, 32'hFFFF_FFF8, 1'b0, 1'b0});
    vq.push_back('{OP_SLT,  32'hFFFF_FFFF, 32'd1, 5'd0, 32'd1, 1'b0, 1'b0});
    vq.push_back('{OP_SLTU, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd0, 1'b1, 1'b0});
    vq.push_back('{OP_SUB,  32'd5, 32'd5, 5'd0, 32'd0, 1'b1, 1'b0});
    vq.push_back('{OP_SLL,  32'd0, 32'd1, 5'd31, 32'h8000_0000, 1'b0, 1'b0});
    vq.push_back('{OP_SRL,  32'd0, 32'h8000_0000, 5'd4, 32'h0800_0000, 1'b0, 1'b0});
    vq.push_back('{OP_RSVD, 32'd7, 32'd3, 5'd0, 32'd0, 1'b1, 1'b0});
    vq.push_back('{OP_MULT, 32'd7, 32'd3, 5'd0, 32'd0, 1'b1, 1'b0});
    run_vectors("legacy", vq);
  endtask

  task automatic test_overflow();
    vec_t vq[$];
    vq.push_back('{OP_ADD, 32'h7FFF_FFFF, 32'd1, 5'd0, 32'h8000_0000, 1'b0, 1'b1});
    vq.push_back('{OP_SUB, 32'h8000_0000, 32'd1, 5'd0, 32'h7FFF_FFFF, 1'b0, 1'b1});
    vq.push_back('{OP_SRA, 32'd0, 32'h8000_0000, 5'd4, 32'hF800_0000, 1'b0, 1'b0});
    vq.push_back('{OP_ADD, 32'h8000_0000, 32'h8000_0000, 5'd0, 32'd0, 1'b1, 1'b1});
    vq.push_back('{OP_SUB, 32'd0, 32'h8000_0000, 5'd0, 32'h8000_0000, 1'b0, 1'b1});
    vq.push_back('{OP_ADD, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd0, 1'b1, 1'b0});
    run_vectors("ovf", vq);
  endtask

  task automatic test_mult();
    run_md("mult", OP_MULT, 32'hFFFF_FFFD, 32'd5, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_md("multu", OP_MULT, 32'hFFFF_FFFF, 32'd2, 1'b1, 32'd1, 32'hFFFF_FFFE);
  endtask

  task automatic test_div();
    run_md("div", OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_md("divu0", OP_DIV, 32'd7, 32'd0, 1'b1, 32'd7, 32'hFFFF_FFFF);
    run_md("divovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h8000_0000);
  endtask

  // MFLO presented while the multiply runs must stall exactly while busy.
  task automatic test_stall();
    int n;
    logic stall_ok;
    @(negedge Clk);
    set_in(OP_MULT, 32'h0001_2345, 32'h0001_0000, 5'd0, 1'b1, 1'b1);
    @(posedge Clk);
    #1;
    set_in(OP_AND, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
    repeat (4) @(posedge Clk);
    @(negedge Clk);
    set_in(OP_MFLO, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1);
    #1;
    checks++;
    if (bus.Stall_EX !== 1'b1) begin
      fails++;
      $display("FAIL stall_assert: got %b expected 1", bus.Stall_EX);
    end
    n = 0;
    stall_ok = 1'b1;
    while (bus.Busy_EX === 1'b1 && n < 200) begin
      if (bus.Stall_EX !== 1'b1) stall_ok = 1'b0;
      @(posedge Clk);
      #1;
      n++;
    end
    checks++;
    if (stall_ok !== 1'b1 || n >= 200) begin
      fails++;
      $display("FAIL stall_hold: got ok=%b cycles=%0d expected ok=1 within bound", stall_ok, n);
    end
    checks++;
    if (bus.Stall_EX !== 1'b0 || bus.Done_EX !== 1'b1) begin
      fails++;
      $display("FAIL stall_release: got stall=%b done=%b expected 0 1", bus.Stall_EX, bus.Done_EX);
    end
    checks++;
    if (bus.ALU_Result_EX !== 32'h2345_0000) begin
      fails++;
      $display("FAIL stall_mflo: got %h expected 23450000", bus.ALU_Result_EX);
    end
    $display("txn stall mflo=%h stalled_cycles=%0d", bus.ALU_Result_EX, n);
    set_in(OP_AND, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
    @(posedge Clk);
    #1;
  endtask

  // Flush mid-divide: no write, no Done, HI/LO keep the previous product.
  task automatic test_flush();
    @(negedge Clk);
    set_in(OP_DIV, 32'd100, 32'd7, 5'd0, 1'b0, 1'b1);
    @(posedge Clk);
    #1;
    set_in(OP_AND, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
    repeat (9) @(posedge Clk);
    @(negedge Clk);
    bus.Flush_EX = 1'b1;
    @(posedge Clk);
    #1;
    bus.Flush_EX = 1'b0;
    checks++;
    if (bus.Busy_EX !== 1'b0 || bus.Done_EX !== 1'b0) begin
      fails++;
      $display("FAIL flush_ctrl: got busy=%b done=%b expected 0 0", bus.Busy_EX, bus.Done_EX);
    end
    @(posedge Clk);
    #1;
    checks++;
    if (bus.Done_EX !== 1'b0) begin
      fails++;
      $display("FAIL flush_nodone: got %b expected 0", bus.Done_EX);
    end
    set_in(OP_MFHI, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1);
    #1;
    checks++;
    if (bus.ALU_Result_EX !== 32'd1) begin
      fails++;
      $display("FAIL flush_hi: got %h expected 00000001", bus.ALU_Result_EX);
    end
    set_in(OP_MFLO, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1);
    #1;
    checks++;
    if (bus.ALU_Result_EX !== 32'h2345_0000) begin
      fails++;
      $display("FAIL flush_lo: got %h expected 23450000", bus.ALU_Result_EX);
    end
    $display("txn flush lo=%h busy=%b", bus.ALU_Result_EX, bus.Busy_EX);
    set_in(OP_AND, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
  endtask

  // A DIVU held while the multiply is busy is accepted on the first idle cycle.
  task automatic test_back_to_back();
    int cyc;
    @(negedge Clk);
    set_in(OP_MULT, 32'd3, 32'd4, 5'd0, 1'b1, 1'b1);
    @(posedge Clk);
    #1;
    set_in(OP_DIV, 32'd20, 32'd3, 5'd0, 1'b1, 1'b1);
    #1;
    checks++;
    if (bus.Stall_EX !== 1'b1) begin
      fails++;
      $display("FAIL b2b_stall: got %b expected 1", bus.Stall_EX);
    end
    wait_not_busy(cyc);
    checks++;
    if (bus.Stall_EX !== 1'b0 || cyc != 33) begin
      fails++;
      $display("FAIL b2b_first: got stall=%b cycles=%0d expected 0 33", bus.Stall_EX, cyc);
    end
    @(posedge Clk);
    #1;
    set_in(OP_AND, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
    checks++;
    if (bus.Busy_EX !== 1'b1) begin
      fails++;
      $display("FAIL b2b_accept: got busy=%b expected 1", bus.Busy_EX);
    end
    wait_not_busy(cyc);
    set_in(OP_MFLO, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1);
    #1;
    checks++;
    if (bus.ALU_Result_EX !== 32'd6) begin
      fails++;
      $display("FAIL b2b_lo: got %h expected 00000006", bus.ALU_Result_EX);
    end
    set_in(OP_MFHI, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1);
    #1;
    checks++;
    if (bus.ALU_Result_EX !== 32'd2) begin
      fails++;
      $display("FAIL b2b_hi: got %h expected 00000002", bus.ALU_Result_EX);
    end
    $display("txn b2b divu hi=%h cycles=%0d", bus.ALU_Result_EX, cyc);
    set_in(OP_AND, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
    @(posedge Clk);
    #1;
  endtask

  // Asynchronous reset mid-multiply discards the operation and clears HI/LO.
  task automatic test_reset_mid();
    @(negedge Clk);
    set_in(OP_MULT, 32'd5, 32'd5, 5'd0, 1'b0, 1'b1);
    @(posedge Clk);
    #1;
    set_in(OP_AND, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
    repeat (5) @(posedge Clk);
    @(negedge Clk);
    Reset_n = 1'b0;
    #1;
    checks++;
    if (bus.Busy_EX !== 1'b0 || bus.Done_EX !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_async: got busy=%b done=%b expected 0 0", bus.Busy_EX, bus.Done_EX);
    end
    #2;
    Reset_n = 1'b1;
    @(posedge Clk);
    #1;
    checks++;
    if (bus.Busy_EX !== 1'b0 || bus.Done_EX !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_after: got busy=%b done=%b expected 0 0", bus.Busy_EX, bus.Done_EX);
    end
    set_in(OP_MFHI, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1);
    #1;
    checks++;
    if (bus.ALU_Result_EX !== 32'd0) begin
      fails++;
      $display("FAIL rstmid_hi: got %h expected 0", bus.ALU_Result_EX);
    end
    set_in(OP_MFLO, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1);
    #1;
    checks++;
    if (bus.ALU_Result_EX !== 32'd0) begin
      fails++;
      $display("FAIL rstmid_lo: got %h expected 0", bus.ALU_Result_EX);
    end
    $display("txn reset_mid lo=%h busy=%b", bus.ALU_Result_EX, bus.Busy_EX);
    set_in(OP_AND, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_legacy();
    test_overflow();
    test_mult();
    test_div();
    test_stall();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
